// File: rtl/io_map_pkg.sv
// io_map_pkg: shared I/O register map for the 0x8000_xxxx window.
// The core's load-mux decode imports the same offsets so both sides agree.
package io_map_pkg;

  localparam int unsigned IO_DATA_W = 32;
  localparam int unsigned IO_BYTE_W = 8;
  localparam int unsigned IO_OFF_W  = 28;

  // Register offsets relative to IO_BASE (low 28 address bits)
  localparam logic [IO_OFF_W-1:0] IO_STATUS  = 28'h000_0000;
  localparam logic [IO_OFF_W-1:0] IO_RXDATA  = 28'h000_0004;
  localparam logic [IO_OFF_W-1:0] IO_TXDATA  = 28'h000_0008;
  localparam logic [IO_OFF_W-1:0] IO_CYCLE   = 28'h000_0010;
  localparam logic [IO_OFF_W-1:0] IO_INSTRET = 28'h000_0014;
  localparam logic [IO_OFF_W-1:0] IO_CNTRST  = 28'h000_0018;

  // Status register payload, MSB first: bit2 overrun, bit1 rx non-empty, bit0 tx free
  typedef struct packed {
    logic tx_overrun;
    logic rx_nonempty;
    logic tx_free;
  } io_status_t;

  // Zero-extend the status payload to a full load word
  function automatic logic [IO_DATA_W-1:0] status_word(input io_status_t s);
    return IO_DATA_W'(s);
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: small byte FIFO buffering UART receive data.
// Ports: clk, rst (async active-low), push/din write side, pop/dout read side
// (dout shows the head entry), full/empty status.
module io_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block for the 0x8000_xxxx window.
// Ports: clk, rst (async active-low); io_addr/io_wdata/io_we/io_re from EX;
// inst_retire from WB; io_rdata registered load data (1-cycle latency);
// tx_data/tx_valid/tx_ready to the UART transmitter; rx_data/rx_valid/rx_ready
// from the UART receiver.
module mmio_io_ctrl
  import io_map_pkg::*;
#(
  parameter int unsigned RX_FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE       = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          io_addr,
  input  logic [IO_DATA_W-1:0] io_wdata,
  input  logic                 io_we,
  input  logic                 io_re,
  input  logic                 inst_retire,
  output logic [IO_DATA_W-1:0] io_rdata,
  output logic [IO_BYTE_W-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [IO_BYTE_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
);

  logic                 sel;
  logic [IO_OFF_W-1:0]  off;
  logic                 wr_tx;
  logic                 wr_cntrst;
  logic                 rd_rx;
  logic                 tx_overrun;
  logic [IO_DATA_W-1:0] cycle_cnt;
  logic [IO_DATA_W-1:0] instret_cnt;
  logic [IO_DATA_W-1:0] rdata_nxt;
  logic [IO_BYTE_W-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  io_status_t           status;
  logic                 unused_wdata;

  assign unused_wdata = ^io_wdata[IO_DATA_W-1:IO_BYTE_W];

  // Address decode
  assign sel       = (io_addr[31:28] == IO_BASE[31:28]);
  assign off       = io_addr[IO_OFF_W-1:0];
  assign wr_tx     = io_we & sel & (off == IO_TXDATA);
  assign wr_cntrst = io_we & sel & (off == IO_CNTRST);
  assign rd_rx     = io_re & sel & (off == IO_RXDATA);

  // RX buffer; rx_ready is simply "not full"
  assign rx_ready = ~fifo_full;

  io_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (IO_BYTE_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid & rx_ready),
    .din   (rx_data),
    .pop   (rd_rx),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign status = '{tx_overrun: tx_overrun, rx_nonempty: ~fifo_empty, tx_free: ~tx_valid};

  // Read mux uses pre-edge state, so same-cycle stores are not reflected
  always_comb begin
    rdata_nxt = '0;
    if (sel) begin
      case (off)
        IO_STATUS:  rdata_nxt = status_word(status);
        IO_RXDATA:  rdata_nxt = fifo_empty ? '0 : IO_DATA_W'(fifo_dout);
        IO_CYCLE:   rdata_nxt = cycle_cnt;
        IO_INSTRET: rdata_nxt = instret_cnt;
        default:    rdata_nxt = '0;
      endcase
    end
  end

  // Load data register: holds until the next load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_rdata <= '0;
    end else if (io_re) begin
      io_rdata <= rdata_nxt;
    end
  end

  // TX holding register; a write while busy is dropped and flagged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (wr_tx) begin
        if (tx_valid) begin
          tx_overrun <= 1'b1;
        end else begin
          tx_data  <= io_wdata[IO_BYTE_W-1:0];
          tx_valid <= 1'b1;
        end
      end
      if (wr_cntrst) tx_overrun <= 1'b0;
    end
  end

  // Performance counters; a counter-reset write beats the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (wr_cntrst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + IO_DATA_W'(1);
      if (inst_retire) instret_cnt <= instret_cnt + IO_DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: directed scenarios followed by random traffic,
// checked against a queue/arithmetic reference model of the register map.
module tb_mmio_io_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic        inst_retire;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  mmio_io_ctrl #(.RX_FIFO_DEPTH(DEPTH), .IO_BASE(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_we       (io_we),
    .io_re       (io_re),
    .inst_retire (inst_retire),
    .io_rdata    (io_rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  logic [7:0]  m_q[$];
  bit          m_busy;
  bit          m_ovr;
  logic [7:0]  m_byte;
  logic [31:0] exp_q[$];
  bit          rd_pending;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void m_reset();
    m_cyc  = 0;
    m_inst = 0;
    m_q.delete();
    m_busy = 0;
    m_ovr  = 0;
    m_byte = 0;
    exp_q.delete();
    rd_pending = 0;
  endfunction

  // Model: evaluate each clock edge from the register-map rules
  always @(posedge clk) begin : model
    bit          sel;
    logic [27:0] off;
    bit          pop;
    bit          push;
    bit          busy_pre;
    logic [31:0] e;
    if (!rst) begin
      m_reset();
    end else begin
      sel = (io_addr[31:28] == 4'h8);
      off = io_addr[27:0];
      pop = 0;
      if (io_re) begin
        e = 32'd0;
        if (sel) begin
          case (off)
            28'h00: e = {29'd0, m_ovr, (m_q.size() != 0), !m_busy};
            28'h04: if (m_q.size() > 0) begin e = {24'd0, m_q[0]}; pop = 1; end
            28'h10: e = m_cyc;
            28'h14: e = m_inst;
            default: e = 32'd0;
          endcase
        end
        exp_q.push_back(e);
        rd_pending = 1;
      end
      push = rx_valid && (m_q.size() < DEPTH);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(rx_data);
      busy_pre = m_busy;
      if (m_busy && tx_ready) m_busy = 0;
      if (io_we && sel && off == 28'h08) begin
        if (busy_pre) m_ovr = 1;
        else begin m_busy = 1; m_byte = io_wdata[7:0]; end
      end
      if (io_we && sel && off == 28'h18) begin
        m_cyc = 0; m_inst = 0; m_ovr = 0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        if (inst_retire) m_inst = m_inst + 32'd1;
      end
    end
  end

  // Monitor: compare load data and the UART-side outputs on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (rd_pending) begin
        rd_pending = 0;
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("io_rdata", io_rdata, exp_q.pop_front());
      end
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy});
      check("tx_data",  {24'd0, tx_data},  {24'd0, m_byte});
      check("rx_ready", {31'd0, rx_ready}, {31'd0, (m_q.size() < DEPTH)});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    io_we = 0; io_re = 0; inst_retire = 0; rx_valid = 0;
  endtask

  task automatic rd(input logic [27:0] off);
    io_addr = BASE | {4'd0, off}; io_re = 1; tick();
  endtask

  task automatic wr(input logic [27:0] off, input logic [31:0] d);
    io_addr = BASE | {4'd0, off}; io_wdata = d; io_we = 1; tick();
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1; tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"},    io_rdata,          32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    rst = 0; io_addr = 0; io_wdata = 0; io_we = 0; io_re = 0;
    inst_retire = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
    m_reset();
    #1;
    check_reset_outputs("por");
    tick(); tick();
    rst = 1;

    // Status after reset, then cycle counter
    rd(28'h00);
    repeat (10) tick();
    rd(28'h10);

    // TX holding with stalled transmitter, overrun, then drain
    tx_ready = 0;
    wr(28'h08, 32'h0000_0041);
    repeat (5) tick();
    wr(28'h08, 32'h0000_0099);
    rd(28'h00);
    tx_ready = 1; tick();
    tx_ready = 0; tick();
    rd(28'h00);
    wr(28'h18, 32'hDEAD_BEEF);
    rd(28'h00);

    // RX FIFO fill, push+pop on full, drain, empty read
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
    rx_data = 8'h55; rx_valid = 1; io_addr = BASE | 32'h4; io_re = 1; tick();
    push_rx(8'h55);
    rd(28'h04); rd(28'h04); rd(28'h04); rd(28'h04);
    rd(28'h04);

    // Retired-instruction counter and counter reset priority
    wr(28'h18, 32'd0);
    repeat (7) begin inst_retire = 1; tick(); end
    rd(28'h14);
    inst_retire = 1; wr(28'h18, 32'd0);
    rd(28'h14);

    // Cycle counter wrap via preload
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFE;
    tick();
    rd(28'h10);
    rd(28'h10);

    // Asynchronous reset mid-TX with the FIFO half full
    tx_ready = 0;
    wr(28'h08, 32'h0000_005A);
    push_rx(8'hA1); push_rx(8'hA2);
    rd(28'h10);
    #1;
    rst = 0;
    m_reset();
    #1;
    check_reset_outputs("mid");
    tick();
    rst = 1;
    rd(28'h00);
    rd(28'h04);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [27:0] off;
      logic [3:0]  hi;
      int unsigned r;
      case ($urandom_range(0, 7))
        0: off = 28'h00;
        1: off = 28'h04;
        2: off = 28'h08;
        3: off = 28'h10;
        4: off = 28'h14;
        5: off = ($urandom_range(0, 7) == 0) ? 28'h18 : 28'h04;
        6: off = 28'h0C;
        default: off = 28'($urandom_range(0, 255)) & 28'hFC;
      endcase
      hi = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h8;
      io_addr     = {hi, off};
      io_wdata    = $urandom;
      r           = $urandom_range(0, 19);
      io_re       = (r < 8) || (r == 19);
      io_we       = (r >= 8 && r < 12) || (r == 19);
      inst_retire = $urandom_range(0, 1) == 1;
      rx_valid    = $urandom_range(0, 2) == 0;
      rx_data     = 8'($urandom);
      tx_ready    = $urandom_range(0, 3) == 0;
      tick();
    end

    tick();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
